// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI arbiter: FSM state encoding and parameter defaults.
// No logic; the helper returns a safe index width for any requester count.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ        = 3;
  localparam int DEF_SPI_DATA_WIDTH = 32;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set request strictly after last_grant, with wrap-around.
// Purely combinational, zero latency; no backpressure.
module rr_picker
  import spi_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic               any,
  output logic [IW-1:0]      index
);

  // Scan farthest candidate first so the nearest one after last_grant overwrites.
  always_comb begin
    any   = 1'b0;
    index = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[IW'((int'(last_grant) + i) % NUM_REQ)]) begin
        any   = 1'b1;
        index = IW'((int'(last_grant) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master among NUM_REQ requesters; grant to o_enable is one cycle, ack one cycle after i_done.
// Requesters hold i_req until o_ack; i_busy stretches GAP. Watchdog enabled by SPI_ARBITER_TIMEOUT_EN.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int SPI_DATA_WIDTH = DEF_SPI_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                                   i_clock,
  input  logic                                   i_reset_n,
  input  logic [NUM_REQ-1:0]                     i_req,
  input  logic [NUM_REQ-1:0][SPI_DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]                     o_ack,
  output logic [SPI_DATA_WIDTH-1:0]              o_rdata,
  output logic                                   o_error,
  output logic                                   o_enable,
  output logic [SPI_DATA_WIDTH-1:0]              o_data,
  input  logic                                   i_done,
  input  logic                                   i_busy,
  input  logic [SPI_DATA_WIDTH-1:0]              i_data
);

  localparam int IW = idx_width(NUM_REQ);

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] grant;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          timeout;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req        (i_req),
    .last_grant (last_grant),
    .any        (pick_any),
    .index      (pick_idx)
  );

`ifdef SPI_ARBITER_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] tmo_cnt;

  // Held at zero outside ISSUE, so it always starts a transaction cleared.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)          tmo_cnt <= '0;
    else if (state == ISSUE) tmo_cnt <= tmo_cnt + 1'b1;
    else                     tmo_cnt <= '0;
  end

  // i_done in the same cycle takes priority over the watchdog.
  assign timeout = (state == ISSUE) && !i_done && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) o_error <= 1'b0;
    else            o_error <= timeout;
  end
`else
  assign timeout = 1'b0;
  assign o_error = 1'b0;
`endif

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any)          state_nxt = ISSUE;
      ISSUE:   if (i_done || timeout) state_nxt = GAP;
      GAP:     if (!i_busy)           state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_enable = (state == ISSUE);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      grant      <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      o_data     <= '0;
      o_rdata    <= '0;
      o_ack      <= '0;
    end else begin
      o_ack <= '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant  <= pick_idx;
            o_data <= i_req_data[pick_idx];
          end
        end
        ISSUE: begin
          if (i_done || timeout) begin
            o_rdata      <= i_done ? i_data : '0;
            o_ack[grant] <= 1'b1;
            last_grant   <= grant;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed self-checking bench for spi_arbiter; build with SPI_ARBITER_TIMEOUT_EN to cover the watchdog.
module tb_spi_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       req;
  logic [2:0][31:0] req_data;
  logic [2:0]       ack;
  logic [31:0]      rdata;
  logic             err;
  logic             enable;
  logic [31:0]      mdata;
  logic             done;
  logic             busy;
  logic [31:0]      sdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_arbiter #(.NUM_REQ(3), .SPI_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .i_clock    (clk),
    .i_reset_n  (rst_n),
    .i_req      (req),
    .i_req_data (req_data),
    .o_ack      (ack),
    .o_rdata    (rdata),
    .o_error    (err),
    .o_enable   (enable),
    .o_data     (mdata),
    .i_done     (done),
    .i_busy     (busy),
    .i_data     (sdata)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; done = 1'b0; busy = 1'b0; sdata = '0; req_data = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_enable(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (enable) begin ok = 1'b1; return; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 3'b111; req_data = '1; done = 1'b1; sdata = '1;
    repeat (2) tick();
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b want 0", enable); end
    checks++; if (mdata !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", mdata); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    checks++; if (ack !== 3'b000 || err !== 1'b0) begin errors++; $display("FAIL reset_ack_err: got %b/%b want 000/0", ack, err); end
    req = '0; rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (ack !== 3'b000 || enable !== 1'b0) begin errors++; $display("FAIL idle_done_ignored: got ack %b en %b want 000/0", ack, enable); end
    done = 1'b0; sdata = '0;
  endtask

  task automatic test_single();
    bit stayed = 1'b1;
    do_reset();
    req_data[1] = 32'h00400007; req = 3'b010;
    tick();
    checks++; if (enable !== 1'b1) begin errors++; $display("FAIL single_enable: got %b want 1", enable); end
    checks++; if (mdata !== 32'h00400007) begin errors++; $display("FAIL single_data: got %h want 00400007", mdata); end
    repeat (39) begin tick(); if (enable !== 1'b1 || ack !== 3'b000) stayed = 1'b0; end
    checks++; if (!stayed) begin errors++; $display("FAIL single_hold: got enable dropped or early ack want steady"); end
    sdata = 32'h1234ABCD; done = 1'b1;
    tick();
    checks++; if (ack !== 3'b010) begin errors++; $display("FAIL single_ack: got %b want 010", ack); end
    checks++; if (rdata !== 32'h1234ABCD || err !== 1'b0) begin errors++; $display("FAIL single_rdata: got %h/%b want 1234abcd/0", rdata, err); end
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL single_gap_enable: got %b want 0", enable); end
    req = '0; done = 1'b0;
    tick();
    checks++; if (ack !== 3'b000) begin errors++; $display("FAIL single_ack_pulse: got %b want 000", ack); end
  endtask

  task automatic test_contention();
    int exp_g[4] = '{0, 1, 2, 0};
    bit ok;
    do_reset();
    req_data[0] = 32'hA0A0A0A0; req_data[1] = 32'hB1B1B1B1; req_data[2] = 32'hC2C2C2C2;
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_enable(ok);
      checks++; if (!ok) begin errors++; $display("FAIL contention_grant%0d: got no enable want enable", k); end
      checks++; if (mdata !== req_data[exp_g[k]]) begin errors++; $display("FAIL contention_data%0d: got %h want %h", k, mdata, req_data[exp_g[k]]); end
      sdata = 32'h100 + 32'(k); done = 1'b1;
      tick();
      checks++; if (ack !== 3'(1 << exp_g[k])) begin errors++; $display("FAIL contention_ack%0d: got %b want %b", k, ack, 3'(1 << exp_g[k])); end
      done = 1'b0;
      tick();
      checks++; if (ack !== 3'b000) begin errors++; $display("FAIL contention_pulse%0d: got %b want 000", k, ack); end
    end
    req = '0;
  endtask

  task automatic test_late();
    bit ok;
    do_reset();
    req_data[0] = 32'hD0D00000; req = 3'b001;
    wait_enable(ok);
    checks++; if (!ok) begin errors++; $display("FAIL late_first: got no enable want enable"); end
    req[1] = 1'b1; req_data[1] = 32'hE1E10000; req_data[0] = 32'hFFFFFFFF;
    repeat (3) tick();
    checks++; if (mdata !== 32'hD0D00000 || enable !== 1'b1) begin errors++; $display("FAIL late_data_stable: got %h/%b want d0d00000/1", mdata, enable); end
    sdata = 32'h0000BEEF; done = 1'b1;
    tick();
    checks++; if (ack !== 3'b001) begin errors++; $display("FAIL late_ack0: got %b want 001", ack); end
    req[0] = 1'b0; done = 1'b0;
    wait_enable(ok);
    checks++; if (!ok || mdata !== 32'hE1E10000) begin errors++; $display("FAIL late_req1_data: got %h want e1e10000", mdata); end
    done = 1'b1;
    tick();
    checks++; if (ack !== 3'b010) begin errors++; $display("FAIL late_ack1: got %b want 010", ack); end
    req = '0; done = 1'b0;
    tick();
  endtask

  task automatic test_busy();
    bit ok;
    bit low = 1'b1;
    do_reset();
    req_data[2] = 32'hC2000002; req = 3'b100;
    wait_enable(ok);
    checks++; if (!ok || mdata !== 32'hC2000002) begin errors++; $display("FAIL busy_first: got %h want c2000002", mdata); end
    done = 1'b1; busy = 1'b1;
    tick();
    checks++; if (ack !== 3'b100) begin errors++; $display("FAIL busy_ack: got %b want 100", ack); end
    done = 1'b0; req = 3'b001; req_data[0] = 32'h0B0B0B0B;
    if (enable) low = 1'b0;
    repeat (4) begin tick(); if (enable) low = 1'b0; end
    busy = 1'b0;
    tick();
    if (enable) low = 1'b0;
    checks++; if (!low) begin errors++; $display("FAIL busy_gap_hold: got enable high in gap want 0"); end
    tick();
    checks++; if (enable !== 1'b1 || mdata !== 32'h0B0B0B0B) begin errors++; $display("FAIL busy_release: got %b/%h want 1/0b0b0b0b", enable, mdata); end
    done = 1'b1;
    tick();
    checks++; if (ack !== 3'b001) begin errors++; $display("FAIL busy_ack2: got %b want 001", ack); end
    done = 1'b0; req = '0;
    tick();
  endtask

  task automatic test_reset_issue();
    bit ok;
    bit no_ack = 1'b1;
    do_reset();
    req_data[0] = 32'h0A0A0000; req_data[1] = 32'h1B1B0000; req = 3'b010;
    wait_enable(ok);
    checks++; if (!ok || mdata !== 32'h1B1B0000) begin errors++; $display("FAIL rstissue_grant: got %h want 1b1b0000", mdata); end
    req = 3'b011;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (enable !== 1'b0 || mdata !== 32'h0) begin errors++; $display("FAIL rstissue_async: got %b/%h want 0/0", enable, mdata); end
    repeat (2) begin tick(); if (ack !== 3'b000) no_ack = 1'b0; end
    rst_n = 1'b1;
    wait_enable(ok);
    if (ack !== 3'b000) no_ack = 1'b0;
    checks++; if (!no_ack) begin errors++; $display("FAIL rstissue_no_ack: got ack pulse want none"); end
    checks++; if (!ok || mdata !== 32'h0A0A0000) begin errors++; $display("FAIL rstissue_req0_first: got %h want 0a0a0000", mdata); end
    done = 1'b1;
    tick();
    checks++; if (ack !== 3'b001) begin errors++; $display("FAIL rstissue_ack: got %b want 001", ack); end
    done = 1'b0; req = '0;
    tick();
  endtask

`ifdef SPI_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    bit quiet = 1'b1;
    do_reset();
    req_data[0] = 32'h00000011; req = 3'b001;
    wait_enable(ok);
    sdata = 32'h00005A5A; done = 1'b1;
    tick();
    checks++; if (rdata !== 32'h00005A5A) begin errors++; $display("FAIL tmo_setup_rdata: got %h want 00005a5a", rdata); end
    done = 1'b0;
    wait_enable(ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_regrant: got no enable want enable"); end
    repeat (15) begin tick(); if (ack !== 3'b000 || enable !== 1'b1) quiet = 1'b0; end
    checks++; if (!quiet) begin errors++; $display("FAIL tmo_early: got early ack or enable drop want none"); end
    tick();
    checks++; if (ack !== 3'b001 || err !== 1'b1) begin errors++; $display("FAIL tmo_fire: got %b/%b want 001/1", ack, err); end
    checks++; if (rdata !== 32'h0 || enable !== 1'b0) begin errors++; $display("FAIL tmo_rdata: got %h/%b want 0/0", rdata, enable); end
    wait_enable(ok);
    repeat (15) tick();
    sdata = 32'h00000077; done = 1'b1;
    tick();
    checks++; if (ack !== 3'b001 || err !== 1'b0 || rdata !== 32'h77) begin errors++; $display("FAIL tmo_done_wins: got %b/%b/%h want 001/0/77", ack, err, rdata); end
    done = 1'b0; req = '0;
    tick();
  endtask
`else
  task automatic test_no_timeout();
    bit ok;
    bit waiting = 1'b1;
    do_reset();
    req = 3'b001;
    wait_enable(ok);
    repeat (40) begin tick(); if (ack !== 3'b000 || enable !== 1'b1 || err !== 1'b0) waiting = 1'b0; end
    checks++; if (!ok || !waiting) begin errors++; $display("FAIL notmo_wait: got ack/enable change want indefinite issue"); end
    sdata = 32'h00000099; done = 1'b1;
    tick();
    checks++; if (ack !== 3'b001 || err !== 1'b0) begin errors++; $display("FAIL notmo_ack: got %b/%b want 001/0", ack, err); end
    done = 1'b0; req = '0;
    tick();
  endtask
`endif

  initial begin
    rst_n = 1'b0; req = '0; done = 1'b0; busy = 1'b0; sdata = '0; req_data = '0;
    test_reset();
    test_single();
    test_contention();
    test_late();
    test_busy();
    test_reset_issue();
`ifdef SPI_ARBITER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
